// File: rtl/spi_m_byte_feeder.sv
// spi_m_byte_feeder
//   Buffers bytes in a small TX FIFO and hands them one at a time to an SPI
//   master using a DV/Ready handshake. It tracks bytes issued but not yet
//   answered by the master's receive pulse, and records sticky error flags.
//
// Ports
//   i_Clk, i_Rst_L            clock (rising edge), async active-low reset
//   i_Wr_Byte, i_Wr_En        FIFO enqueue, one byte per cycle
//   o_Full, o_Count           FIFO status
//   o_TX_Byte, o_TX_DV        byte and single-cycle valid to the SPI master
//   i_TX_Ready                SPI master ready for next byte
//   i_RX_Byte, i_RX_DV        byte received by the SPI master
//   o_RX_Byte, o_RX_DV        registered copy of the receive side
//   o_Pending                 issued-but-unanswered bytes (saturates at 15)
//   o_Busy                    transfer in flight, data queued or answers owed
//   i_Err_Clr, o_Err          sticky {timeout, unexpected RX, overflow}
module spi_m_byte_feeder #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [7:0]             i_Wr_Byte,
    input  logic                   i_Wr_En,
    output logic                   o_Full,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic [7:0]             o_TX_Byte,
    output logic                   o_TX_DV,
    input  logic                   i_TX_Ready,
    input  logic [7:0]             i_RX_Byte,
    input  logic                   i_RX_DV,
    output logic [7:0]             o_RX_Byte,
    output logic                   o_RX_DV,
    output logic [3:0]             o_Pending,
    output logic                   o_Busy,
    input  logic                   i_Err_Clr,
    output logic [2:0]             o_Err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pop, timeout;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, ovf;

    logic          pend_inc, pend_dec, unexp_rx;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a write.
    assign o_Full  = (o_Count == CW'(DEPTH));
    assign wr_ok   = i_Wr_En && !o_Full;
    assign ovf     = i_Wr_En && o_Full;
    assign o_TX_DV = (state_q == ISSUE);
    assign o_Busy  = (state_q != IDLE) || (o_Count != '0) || (o_Pending != '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if ((o_Count != '0) && i_TX_Ready) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
                tmr_d   = '0;
            end
            WAIT_LOW: begin
                // The master must show it took the byte by dropping ready;
                // give up after ACK_TIMEOUT cycles of ready still high.
                if (!i_TX_Ready) begin
                    state_d = WAIT_HIGH;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (i_TX_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge i_Clk) begin
        if (wr_ok) mem[wr_ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_Count   <= '0;
            o_TX_Byte <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_TX_Byte <= mem[rd_ptr];
            end
            case ({wr_ok, pop})
                2'b10:   o_Count <= o_Count + 1'b1;
                2'b01:   o_Count <= o_Count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------- RX, pending, errors
    assign pend_inc = (state_q == ISSUE);
    assign pend_dec = i_RX_DV;
    // An answer arriving in the issue cycle is treated as balancing the
    // new byte, so it is never flagged as unexpected.
    assign unexp_rx = pend_dec && !pend_inc && (o_Pending == '0);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_Byte <= '0;
            o_RX_DV   <= 1'b0;
            o_Pending <= '0;
            o_Err     <= '0;
        end else begin
            o_RX_DV <= i_RX_DV;
            if (i_RX_DV) o_RX_Byte <= i_RX_Byte;

            if (pend_inc && !pend_dec) begin
                if (o_Pending != 4'hF) o_Pending <= o_Pending + 1'b1;
            end else if (pend_dec && !pend_inc) begin
                if (o_Pending != '0) o_Pending <= o_Pending - 1'b1;
            end

            // New events override a clear in the same cycle.
            o_Err <= (i_Err_Clr ? 3'b000 : o_Err) | {timeout, unexp_rx, ovf};
        end
    end

endmodule

// File: tb/tb_spi_m_byte_feeder.sv
module tb_spi_m_byte_feeder;

  localparam int DEPTH  = 8;
  localparam int ACK_TO = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b1;
  logic [7:0]    i_Wr_Byte = '0;
  logic          i_Wr_En = 1'b0;
  logic          o_Full;
  logic [CW-1:0] o_Count;
  logic [7:0]    o_TX_Byte;
  logic          o_TX_DV;
  logic          i_TX_Ready = 1'b1;
  logic [7:0]    i_RX_Byte = '0;
  logic          i_RX_DV = 1'b0;
  logic [7:0]    o_RX_Byte;
  logic          o_RX_DV;
  logic [3:0]    o_Pending;
  logic          o_Busy;
  logic          i_Err_Clr = 1'b0;
  logic [2:0]    o_Err;

  spi_m_byte_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .i_Wr_Byte(i_Wr_Byte), .i_Wr_En(i_Wr_En),
    .o_Full(o_Full), .o_Count(o_Count),
    .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
    .i_RX_Byte(i_RX_Byte), .i_RX_DV(i_RX_DV),
    .o_RX_Byte(o_RX_Byte), .o_RX_DV(o_RX_DV),
    .o_Pending(o_Pending), .o_Busy(o_Busy),
    .i_Err_Clr(i_Err_Clr), .o_Err(o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];
  int         exp_pend;
  logic [2:0] exp_err;
  logic       exp_rxdv;
  logic [7:0] exp_rxb;
  bit         prev_dv, ack_wait;
  int         wl_cnt, since_dv;

  // SPI master model
  bit         m_en = 1'b1;
  bit         m_noack = 1'b0;
  int         m_hold, m_cd;
  logic [7:0] m_byte, m_byte_rx;

  task automatic model_clear();
    mq.delete(); tx_log.delete(); rx_log.delete();
    exp_pend = 0; exp_err = '0; exp_rxdv = 1'b0; exp_rxb = '0;
    prev_dv = 1'b0; ack_wait = 1'b0; wl_cnt = 0; since_dv = 100;
    m_hold = 0; m_cd = -1; m_byte = '0; m_byte_rx = '0;
  endtask

  // One clock: predict from the inputs at this edge, advance, compare, then
  // let the master model react to what it sees.
  task automatic cyc();
    bit inc, dec, ovf, unexp, tmo;
    int pre_size;
    logic [7:0] hb;
    inc = prev_dv;
    dec = i_RX_DV;
    pre_size = mq.size();
    ovf = i_Wr_En && (pre_size == DEPTH);
    unexp = dec && !inc && (exp_pend == 0);
    tmo = 1'b0;
    if (ack_wait) begin
      if (!i_TX_Ready) ack_wait = 1'b0;
      else begin
        wl_cnt++;
        if (wl_cnt == ACK_TO) begin tmo = 1'b1; ack_wait = 1'b0; end
      end
    end
    if (inc) begin ack_wait = 1'b1; wl_cnt = 0; end
    if (inc && !dec) exp_pend = (exp_pend == 15) ? 15 : exp_pend + 1;
    else if (dec && !inc && exp_pend > 0) exp_pend--;
    exp_err = (i_Err_Clr ? 3'b000 : exp_err) | {tmo, unexp, ovf};
    exp_rxdv = i_RX_DV;
    if (i_RX_DV) exp_rxb = i_RX_Byte;
    if (i_Wr_En && pre_size < DEPTH) mq.push_back(i_Wr_Byte);

    @(posedge i_Clk); #1;

    since_dv++;
    if (o_TX_DV === 1'b1) begin
      checks++;
      if (since_dv < 3 || pre_size == 0) begin
        errors++;
        $display("FAIL dv_timing: gap=%0d queued=%0d, required gap>=3 and queued>0", since_dv, pre_size);
      end
      since_dv = 0;
      if (mq.size() > 0) begin
        hb = mq.pop_front();
        checks++;
        if (o_TX_Byte !== hb) begin
          errors++; $display("FAIL tx_byte: got %02h expected %02h", o_TX_Byte, hb);
        end
        tx_log.push_back(o_TX_Byte);
      end
    end
    prev_dv = (o_TX_DV === 1'b1);

    checks++;
    if (o_Count !== CW'(mq.size())) begin
      errors++; $display("FAIL count: got %0d expected %0d", o_Count, mq.size());
    end
    checks++;
    if (o_Full !== (mq.size() == DEPTH)) begin
      errors++; $display("FAIL full: got %b expected %b", o_Full, (mq.size() == DEPTH));
    end
    checks++;
    if (o_Pending !== 4'(exp_pend)) begin
      errors++; $display("FAIL pending: got %0d expected %0d", o_Pending, exp_pend);
    end
    checks++;
    if (o_Err !== exp_err) begin
      errors++; $display("FAIL err: got %b expected %b", o_Err, exp_err);
    end
    checks++;
    if (o_RX_DV !== exp_rxdv || o_RX_Byte !== exp_rxb) begin
      errors++; $display("FAIL rx: got dv=%b byte=%02h expected dv=%b byte=%02h", o_RX_DV, o_RX_Byte, exp_rxdv, exp_rxb);
    end
    if (mq.size() != 0 || exp_pend != 0) begin
      checks++;
      if (o_Busy !== 1'b1) begin
        errors++; $display("FAIL busy: got %b expected 1 (queued=%0d pending=%0d)", o_Busy, mq.size(), exp_pend);
      end
    end
    if (o_RX_DV === 1'b1) rx_log.push_back(o_RX_Byte);

    if (m_en) begin
      i_RX_DV = 1'b0;
      if (o_TX_DV === 1'b1 && !m_noack) begin
        i_TX_Ready = 1'b0;
        m_hold = $urandom_range(2, 4);
        m_byte = o_TX_Byte;
      end else if (!i_TX_Ready && m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          i_TX_Ready = 1'b1;
          m_cd = $urandom_range(0, 2);
          m_byte_rx = m_byte;
        end
      end
      if (m_cd == 0) begin i_RX_DV = 1'b1; i_RX_Byte = m_byte_rx; end
      if (m_cd >= 0) m_cd--;
    end
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    i_Wr_En = 1'b0; i_Err_Clr = 1'b0; i_RX_DV = 1'b0; i_TX_Ready = 1'b1;
    #2;
    checks++;
    if ({o_Full, o_Count, o_TX_Byte, o_TX_DV, o_RX_Byte, o_RX_DV, o_Pending, o_Busy, o_Err} !== '0) begin
      errors++;
      $display("FAIL reset_async: full=%b cnt=%0d txb=%02h dv=%b rxb=%02h rxdv=%b pend=%0d busy=%b err=%b, required all 0",
               o_Full, o_Count, o_TX_Byte, o_TX_DV, o_RX_Byte, o_RX_DV, o_Pending, o_Busy, o_Err);
    end
    repeat (2) @(posedge i_Clk);
    #1;
    checks++;
    if ({o_Full, o_Count, o_TX_DV, o_Pending, o_Busy, o_Err} !== '0) begin
      errors++; $display("FAIL reset_held: cnt=%0d dv=%b pend=%0d busy=%b err=%b, required 0", o_Count, o_TX_DV, o_Pending, o_Busy, o_Err);
    end
    i_Rst_L = 1'b1;
    model_clear();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    i_Wr_En = 1'b0;
    while ((mq.size() != 0 || exp_pend != 0 || ack_wait || !i_TX_Ready || m_cd >= 0 || o_Busy !== 1'b0) && n < bound) begin
      cyc(); n++;
    end
    checks++;
    if (n >= bound) begin
      errors++; $display("FAIL drain: still busy after %0d cycles (queued=%0d pending=%0d)", n, mq.size(), exp_pend);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  // First byte after reset; also confirms the first DV is after edge 2.
  task automatic test_single();
    m_en = 1'b1; m_noack = 1'b0;
    i_Wr_En = 1'b1; i_Wr_Byte = 8'hA5;
    cyc();
    checks++;
    if (o_Count !== CW'(1) || o_TX_DV !== 1'b0) begin
      errors++; $display("FAIL single_edge1: cnt=%0d dv=%b expected cnt=1 dv=0", o_Count, o_TX_DV);
    end
    i_Wr_En = 1'b0;
    cyc();
    checks++;
    if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'hA5 || o_Count !== CW'(0)) begin
      errors++; $display("FAIL single_issue: dv=%b byte=%02h cnt=%0d expected dv=1 byte=a5 cnt=0", o_TX_DV, o_TX_Byte, o_Count);
    end
    cyc();
    checks++;
    if (o_TX_DV !== 1'b0 || o_Pending !== 4'd1) begin
      errors++; $display("FAIL single_after: dv=%b pend=%0d expected dv=0 pend=1", o_TX_DV, o_Pending);
    end
    drain(100);
    checks++;
    if (o_Pending !== 4'd0 || o_Busy !== 1'b0) begin
      errors++; $display("FAIL single_done: pend=%0d busy=%b expected 0 0", o_Pending, o_Busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    m_en = 1'b0; i_TX_Ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      i_Wr_En = 1'b1; i_Wr_Byte = 8'(i);
      cyc();
    end
    i_Wr_En = 1'b0;
    cyc();
    checks++;
    if (o_Full !== 1'b1 || o_Count !== CW'(8) || o_Err !== 3'b001) begin
      errors++; $display("FAIL overflow: full=%b cnt=%0d err=%b expected 1 8 001", o_Full, o_Count, o_Err);
    end
    m_en = 1'b1; i_TX_Ready = 1'b1;
    drain(300);
    checks++;
    if (tx_log.size() != 8) begin
      errors++; $display("FAIL overflow_txcount: got %0d bytes expected 8", tx_log.size());
    end
    for (int i = 0; i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL overflow_order: slot %0d got %02h expected %02h", i, tx_log[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    m_en = 1'b1; m_noack = 1'b1; i_TX_Ready = 1'b1;
    i_Wr_En = 1'b1; i_Wr_Byte = 8'h11; cyc();
    i_Wr_Byte = 8'h22; cyc();
    i_Wr_En = 1'b0;
    checks++;
    if (o_TX_DV !== 1'b1) begin
      errors++; $display("FAIL timeout_dv1: dv=%b expected 1", o_TX_DV);
    end
    for (int i = 0; i < ACK_TO; i++) begin
      cyc();
      checks++;
      if (o_Err[2] !== 1'b0) begin
        errors++; $display("FAIL timeout_early: wait cycle %0d err2=%b expected 0", i + 1, o_Err[2]);
      end
    end
    cyc();
    checks++;
    if (o_Err[2] !== 1'b1 || o_TX_DV !== 1'b0) begin
      errors++; $display("FAIL timeout_flag: err2=%b dv=%b expected 1 0", o_Err[2], o_TX_DV);
    end
    cyc();
    checks++;
    if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h22) begin
      errors++; $display("FAIL timeout_next: dv=%b byte=%02h expected 1 22", o_TX_DV, o_TX_Byte);
    end
    repeat (3) cyc();
    m_noack = 1'b0;
  endtask

  task automatic test_unexpected_rx();
    do_reset();
    m_en = 1'b0; i_TX_Ready = 1'b1;
    i_RX_DV = 1'b1; i_RX_Byte = 8'h3C;
    cyc();
    i_RX_DV = 1'b0;
    checks++;
    if (o_RX_DV !== 1'b1 || o_RX_Byte !== 8'h3C || o_Err !== 3'b010 || o_Pending !== 4'd0) begin
      errors++; $display("FAIL unexp_rx: rxdv=%b rxb=%02h err=%b pend=%0d expected 1 3c 010 0", o_RX_DV, o_RX_Byte, o_Err, o_Pending);
    end
    cyc();
    checks++;
    if (o_RX_DV !== 1'b0) begin
      errors++; $display("FAIL rxdv_pulse: rxdv=%b expected 0", o_RX_DV);
    end
    i_Err_Clr = 1'b1; cyc(); i_Err_Clr = 1'b0;
    checks++;
    if (o_Err !== 3'b000) begin
      errors++; $display("FAIL err_clr: err=%b expected 000", o_Err);
    end
    // clear and a fresh event together: the event wins
    i_Err_Clr = 1'b1; i_RX_DV = 1'b1; i_RX_Byte = 8'h5A;
    cyc();
    i_Err_Clr = 1'b0; i_RX_DV = 1'b0;
    checks++;
    if (o_Err !== 3'b010 || o_RX_Byte !== 8'h5A) begin
      errors++; $display("FAIL clr_vs_set: err=%b rxb=%02h expected 010 5a", o_Err, o_RX_Byte);
    end
    i_Err_Clr = 1'b1; cyc(); i_Err_Clr = 1'b0;
    m_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int dvs;
    do_reset();
    m_en = 1'b1; i_TX_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_Wr_En = 1'b1; i_Wr_Byte = 8'hC0 + 8'(i); cyc();
    end
    i_Wr_En = 1'b0;
    cyc();  // transfer is now waiting for ready to return
    checks++;
    if (o_Busy !== 1'b1 || o_TX_DV !== 1'b0) begin
      errors++; $display("FAIL mid_state: busy=%b dv=%b expected 1 0", o_Busy, o_TX_DV);
    end
    do_reset();
    dvs = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (o_TX_DV === 1'b1) dvs++;
    end
    checks++;
    if (dvs != 0) begin
      errors++; $display("FAIL mid_reset_dv: got %0d pulses expected 0", dvs);
    end
    i_Wr_En = 1'b1; i_Wr_Byte = 8'h77; cyc(); i_Wr_En = 1'b0;
    drain(100);
    checks++;
    if (tx_log.size() != 1) begin
      errors++; $display("FAIL mid_after: got %0d bytes expected 1", tx_log.size());
    end
  endtask

  task automatic test_loopback();
    do_reset();
    m_en = 1'b1; i_TX_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_Wr_En = 1'b1; i_Wr_Byte = 8'h10 + 8'(i); cyc();
    end
    i_Wr_En = 1'b0;
    drain(300);
    checks++;
    if (rx_log.size() != 8) begin
      errors++; $display("FAIL loop_count: got %0d rx bytes expected 8", rx_log.size());
    end
    for (int i = 0; i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL loop_rx: slot %0d got %02h expected %02h", i, rx_log[i], 8'h10 + 8'(i));
      end
    end
    checks++;
    if (o_Pending !== 4'd0 || o_Busy !== 1'b0 || o_Err !== 3'b000) begin
      errors++; $display("FAIL loop_end: pend=%0d busy=%b err=%b expected 0 0 000", o_Pending, o_Busy, o_Err);
    end
  endtask

  task automatic test_random();
    bit burst;
    do_reset();
    m_en = 1'b1; m_noack = 1'b0; i_TX_Ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      burst = ((c / 50) % 2) == 0;
      i_Wr_En   = burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      i_Wr_Byte = 8'($urandom);
      i_Err_Clr = ($urandom_range(0, 24) == 0);
      cyc();
    end
    i_Err_Clr = 1'b0;
    drain(400);
    checks++;
    if (o_Busy !== 1'b0 || o_Pending !== 4'd0) begin
      errors++; $display("FAIL random_end: busy=%b pend=%0d expected 0 0", o_Busy, o_Pending);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_single();
    test_overflow();
    test_timeout();
    test_unexpected_rx();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
